serial_adder: RTL

- Bit-serial ripple adder; the inverse operation of the team's full subtractor. Summing difference D with subtrahend B recovers minuend A.
- One full-adder cell is reused over WIDTH cycles, LSB first, with a registered carry.
- Used as the lightweight add-back / check stage beside the subtractor datapath.
- Start/busy/done handshake, plus a serial bit stream output for downstream monitors.

---
 rtl/serial_adder.sv | 109 ++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell reused WIDTH cycles, LSB first,
// with a registered carry. Produces {cout,sum} = a + b + cin and a serial bit stream.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             sum_bit,
   output logic             sum_bit_valid,
   output logic [1:0]       dbg_state
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sa, sb, acc;
   logic             c;
   logic [CW-1:0]    cnt;
   logic             s, c_nxt, last, load;

   // Handshake: start is accepted only in IDLE or DONE (load=1); while busy it is ignored.
   // done is high for exactly the one cycle spent in DONE.
   assign s         = sa[0] ^ sb[0] ^ c;
   assign c_nxt     = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
   assign last      = (cnt == CW'(WIDTH - 1));
   assign busy      = (state == SHIFT);
   assign done      = (state == DONE);
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SHIFT;
               load      = 1'b1;
            end
         end
         SHIFT: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            if (start) begin
               state_nxt = SHIFT;
               load      = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sa            <= '0;
         sb            <= '0;
         acc           <= '0;
         c             <= 1'b0;
         cnt           <= '0;
         sum           <= '0;
         cout          <= 1'b0;
         sum_bit       <= 1'b0;
         sum_bit_valid <= 1'b0;
      end else begin
         sum_bit_valid <= 1'b0;
         if (load) begin
            sa  <= a;
            sb  <= b;
            c   <= cin;
            cnt <= '0;
         end else if (state == SHIFT) begin
            sa            <= sa >> 1;
            sb            <= sb >> 1;
            c             <= c_nxt;
            acc           <= {s, acc[WIDTH-1:1]};
            sum_bit       <= s;
            sum_bit_valid <= 1'b1;
            cnt           <= cnt + CW'(1);
            // The final bit is merged directly so sum is complete at the DONE cycle.
            if (last) begin
               sum  <= {s, acc[WIDTH-1:1]};
               cout <= c_nxt;
            end
         end
      end
   end

endmodule
